// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch sequencer. It walks a three-state
// loop (IDLE -> FETCH -> EXEC) and reads one instruction word per pass from
// a program memory. During EXEC it presents the captured word to a decoder.
// At the end of EXEC it advances the PC, or loads it with an absolute or
// PC-relative target that the decoder supplies.
//
// Memory handshake: prog_req is a level request. It stays high, with
// prog_addr held at pc, for every cycle the unit is in FETCH. The memory
// answers with a single-cycle prog_ack and presents prog_data in that same
// cycle. A request completes on a rising edge where prog_req and prog_ack
// are both high. An ack in any other cycle is ignored.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   reset        in   synchronous, active-high; forces IDLE, pc=0, instruction=0
//   run          in   fetch enable; sampled in IDLE and at the end of EXEC
//   prog_addr    out  [PC_WIDTH] program memory address (always equal to pc)
//   prog_req     out  program memory read request (high in FETCH)
//   prog_ack     in   read acknowledge; prog_data valid in the same cycle
//   prog_data    in   [PROGRAM_DataWidth] program memory read data
//   instruction  out  [PROGRAM_DataWidth] registered instruction word
//   instr_valid  out  high during the single EXEC cycle
//   cnt_wr_en    in   decoder: load pc instead of incrementing
//   add_offset   in   decoder: the load is pc-relative (pc + signed offset)
//   literal_adr  in   [PC_WIDTH] absolute target or two's-complement offset
//   pc           out  [PC_WIDTH] current program counter
//   fsm_state    out  [2] raw FSM state (0 IDLE, 1 FETCH, 2 EXEC) for debug
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int PC_WIDTH          = 8,
   parameter int PROGRAM_DataWidth = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   output logic [PC_WIDTH-1:0]          prog_addr,
   output logic                         prog_req,
   input  logic                         prog_ack,
   input  logic [PROGRAM_DataWidth-1:0] prog_data,
   output logic [PROGRAM_DataWidth-1:0] instruction,
   output logic                         instr_valid,
   input  logic                         cnt_wr_en,
   input  logic                         add_offset,
   input  logic [PC_WIDTH-1:0]          literal_adr,
   output logic [PC_WIDTH-1:0]          pc,
   output logic [1:0]                   fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

   state_t                         state_q, state_d;
   logic [PC_WIDTH-1:0]            pc_q, pc_d;
   logic [PROGRAM_DataWidth-1:0]   instr_q, instr_d;
   logic [PC_WIDTH-1:0]            next_pc;

   // Relative loads use the branch instruction's own address (pc_q is not
   // advanced until the end of EXEC). Plain modular addition gives both the
   // signed-offset behaviour and the wrap from all-ones back to zero.
   always_comb begin
      next_pc = pc_q + PC_ONE;
      if (cnt_wr_en) begin
         if (add_offset) next_pc = pc_q + literal_adr;
         else            next_pc = literal_adr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // pc and instruction change in only one state each. This keeps acks
   // outside FETCH and decoder inputs outside EXEC from having any effect.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            // run is deliberately not looked at here: a started fetch always completes.
            if (prog_ack) begin
               instr_d = prog_data;
               state_d = EXEC;
            end
         end
         EXEC: begin
            pc_d    = next_pc;
            state_d = run ? FETCH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All outputs are decoded from registered state only.
   assign prog_req    = (state_q == FETCH);
   assign instr_valid = (state_q == EXEC);
   assign prog_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign fsm_state   = state_q;

endmodule
